// File: rtl/sim_status_mmio.sv
// Test-status and console peripheral on the CPU data bus: latches the program's
// pass/fail word, drains buffered console bytes, then raises done.
module sim_status_mmio #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] PASS_CODE  = 32'h777,
    parameter logic [3:0]  REGION     = 4'h1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] dbus_cmd_addr_i,
    input  logic        dbus_cmd_we_i,
    input  logic        dbus_cmd_re_i,
    input  logic [31:0] dbus_wdata_data_i,
    output logic [31:0] dbus_rdata_data_o,
    output logic        dbus_rdata_valid_o,
    output logic        con_valid_o,
    output logic [7:0]  con_data_o,
    input  logic        con_ready_i,
    output logic        done_o,
    output logic        pass_o,
    output logic [31:0] code_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] OFF_STATUS  = 2'd0;
    localparam logic [1:0] OFF_CONSOLE = 2'd1;
    localparam logic [1:0] OFF_CYC_LO  = 2'd2;
    localparam logic [1:0] OFF_CYC_HI  = 2'd3;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_d;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [63:0]   cycle;
    logic [31:0]   shadow_hi;

    logic       hit, wr, rd;
    logic [1:0] offset;
    logic       full, empty, push, pop, status_wr;
    logic       unused;

    assign hit    = (dbus_cmd_addr_i[31:28] == REGION);
    assign offset = dbus_cmd_addr_i[3:2];
    assign unused = ^{dbus_cmd_addr_i[27:4], dbus_cmd_addr_i[1:0]};

    // A simultaneous write and read strobe is treated as a write only.
    assign wr = hit & dbus_cmd_we_i;
    assign rd = hit & dbus_cmd_re_i & ~dbus_cmd_we_i;

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);

    // Full is taken before this cycle's pop, so push-on-full is dropped even if a pop frees a slot.
    assign pop       = ~empty & con_ready_i;
    assign push      = wr & (offset == OFF_CONSOLE) & ~full & (state == RUN);
    assign status_wr = wr & (offset == OFF_STATUS) & (state == RUN);

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= dbus_wdata_data_i[7:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= RUN;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            RUN:     if (status_wr) state_d = DRAIN;
            DRAIN:   if (empty) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            code_o <= '0;
            pass_o <= 1'b0;
        end else if (status_wr) begin
            code_o <= dbus_wdata_data_i;
            pass_o <= (dbus_wdata_data_i == PASS_CODE);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cycle <= '0;
        end else begin
            cycle <= cycle + 64'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            dbus_rdata_data_o  <= '0;
            dbus_rdata_valid_o <= 1'b0;
            shadow_hi          <= '0;
        end else begin
            dbus_rdata_valid_o <= rd;
            if (rd) begin
                case (offset)
                    OFF_STATUS:  dbus_rdata_data_o <= {29'b0, full, done_o, pass_o};
                    OFF_CONSOLE: dbus_rdata_data_o <= 32'(count);
                    OFF_CYC_LO: begin
                        dbus_rdata_data_o <= cycle[31:0];
                        shadow_hi         <= cycle[63:32];
                    end
                    OFF_CYC_HI:  dbus_rdata_data_o <= shadow_hi;
                    default:     dbus_rdata_data_o <= '0;
                endcase
            end
        end
    end

    assign done_o      = (state == DONE);
    assign con_valid_o = ~empty;
    assign con_data_o  = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_sim_status_mmio.sv
// Directed bench for sim_status_mmio: status latching, console FIFO, drain/done and cycle counter.
module tb_sim_status_mmio;

    localparam logic [31:0] A_STAT = 32'h1000_0000;
    localparam logic [31:0] A_CON  = 32'h1000_0004;
    localparam logic [31:0] A_LO   = 32'h1000_0008;
    localparam logic [31:0] A_HI   = 32'h1000_000C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready = 1'b0;
    logic        done;
    logic        pass;
    logic [31:0] code;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sim_status_mmio #(
        .FIFO_DEPTH(8),
        .PASS_CODE(32'h777),
        .REGION(4'h1)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .dbus_cmd_addr_i(addr),
        .dbus_cmd_we_i(we),
        .dbus_cmd_re_i(re),
        .dbus_wdata_data_i(wdata),
        .dbus_rdata_data_o(rdata),
        .dbus_rdata_valid_o(rvalid),
        .con_valid_o(con_valid),
        .con_data_o(con_data),
        .con_ready_i(con_ready),
        .done_o(done),
        .pass_o(pass),
        .code_o(code)
    );

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        we = 1'b0;
        re = 1'b0;
        con_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a;
        wdata = d;
        we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
        @(negedge clk);
        addr = a;
        re = 1'b1;
        @(negedge clk);
        re = 1'b0;
        d = rdata;
        v = rvalid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({done, pass, code, con_valid, con_data, rvalid, rdata} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: done=%b pass=%b code=%h cv=%b cd=%h rv=%b rd=%h required all 0",
                     done, pass, code, con_valid, con_data, rvalid, rdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_pass();
        logic [31:0] d;
        logic v;
        do_reset();
        bus_write(A_STAT, 32'h777);
        checks++;
        if (done !== 1'b0 || pass !== 1'b1 || code !== 32'h777) begin
            failures++;
            $display("FAIL pass_edge1: done=%b pass=%b code=%h required 0 1 777", done, pass, code);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL pass_edge2_done: got %b required 1", done);
        end
        bus_read(A_STAT, d, v);
        checks++;
        if (v !== 1'b1 || d !== 32'h3) begin
            failures++;
            $display("FAIL status_read_done: valid=%b data=%h required 1 00000003", v, d);
        end
    endtask

    task automatic test_console_drain();
        logic bad;
        do_reset();
        bus_write(A_CON, 32'h48);
        bus_write(A_CON, 32'h169);
        bus_write(A_STAT, 32'h5);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || con_valid !== 1'b1 || con_data !== 8'h48) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL console_hold: done=%b cv=%b cd=%h required 0 1 48", done, con_valid, con_data);
        end
        con_ready = 1'b1;
        checks++;
        if (con_valid !== 1'b1 || con_data !== 8'h48) begin
            failures++;
            $display("FAIL console_byte0: cv=%b cd=%h required 1 48", con_valid, con_data);
        end
        @(negedge clk);
        checks++;
        if (con_valid !== 1'b1 || con_data !== 8'h69 || done !== 1'b0) begin
            failures++;
            $display("FAIL console_byte1: cv=%b cd=%h done=%b required 1 69 0", con_valid, con_data, done);
        end
        @(negedge clk);
        checks++;
        if (con_valid !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL console_last_pop: cv=%b done=%b required 0 0", con_valid, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || pass !== 1'b0 || code !== 32'h5) begin
            failures++;
            $display("FAIL console_done: done=%b pass=%b code=%h required 1 0 5", done, pass, code);
        end
        con_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic v;
        logic bad;
        do_reset();
        for (int i = 0; i < 9; i++) bus_write(A_CON, 32'(i));
        bus_read(A_STAT, d, v);
        checks++;
        if (v !== 1'b1 || d !== 32'h4) begin
            failures++;
            $display("FAIL ovf_status_full: valid=%b data=%h required 1 00000004", v, d);
        end
        bus_read(A_CON, d, v);
        checks++;
        if (v !== 1'b1 || d !== 32'd8) begin
            failures++;
            $display("FAIL ovf_count8: valid=%b data=%h required 1 00000008", v, d);
        end
        // full FIFO, pop and push in the same cycle
        @(negedge clk);
        addr = A_CON;
        wdata = 32'hAA;
        we = 1'b1;
        con_ready = 1'b1;
        checks++;
        if (con_data !== 8'h00) begin
            failures++;
            $display("FAIL ovf_head0: got %h required 00", con_data);
        end
        @(negedge clk);
        we = 1'b0;
        con_ready = 1'b0;
        bus_read(A_CON, d, v);
        checks++;
        if (v !== 1'b1 || d !== 32'd7) begin
            failures++;
            $display("FAIL full_pushpop_count7: valid=%b data=%h required 1 00000007", v, d);
        end
        con_ready = 1'b1;
        bad = 1'b0;
        for (int i = 1; i < 8; i++) begin
            if (con_valid !== 1'b1 || con_data !== 8'(i)) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad || con_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovf_drain_order: bad=%b final cv=%b required 0 0", bad, con_valid);
        end
        con_ready = 1'b0;
        // push and pop together on a non-full FIFO keep the count
        bus_write(A_CON, 32'h11);
        addr = A_CON;
        wdata = 32'h22;
        we = 1'b1;
        con_ready = 1'b1;
        @(negedge clk);
        we = 1'b0;
        con_ready = 1'b0;
        checks++;
        if (con_valid !== 1'b1 || con_data !== 8'h22) begin
            failures++;
            $display("FAIL pushpop_head: cv=%b cd=%h required 1 22", con_valid, con_data);
        end
        bus_read(A_CON, d, v);
        checks++;
        if (v !== 1'b1 || d !== 32'd1) begin
            failures++;
            $display("FAIL pushpop_count1: valid=%b data=%h required 1 00000001", v, d);
        end
    endtask

    task automatic test_cycle();
        logic [31:0] d;
        logic v;
        do_reset();
        bus_read(A_LO, d, v);
        checks++;
        if (v !== 1'b1 || d !== 32'd1) begin
            failures++;
            $display("FAIL cycle_lo_after_reset: valid=%b data=%h required 1 00000001", v, d);
        end
        bus_read(A_HI, d, v);
        checks++;
        if (v !== 1'b1 || d !== 32'd0) begin
            failures++;
            $display("FAIL cycle_hi_after_reset: valid=%b data=%h required 1 00000000", v, d);
        end
        @(negedge clk);
        force dut.cycle = 64'h0000_0001_FFFF_FFFF;
        #1;
        release dut.cycle;
        addr = A_LO;
        re = 1'b1;
        @(negedge clk);
        re = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL cycle_lo_near_carry: valid=%b data=%h required 1 ffffffff", rvalid, rdata);
        end
        bus_read(A_HI, d, v);
        checks++;
        if (v !== 1'b1 || d !== 32'd1) begin
            failures++;
            $display("FAIL cycle_hi_snapshot: valid=%b data=%h required 1 00000001", v, d);
        end
        repeat (5) @(negedge clk);
        bus_read(A_HI, d, v);
        checks++;
        if (v !== 1'b1 || d !== 32'd1) begin
            failures++;
            $display("FAIL cycle_hi_stable: valid=%b data=%h required 1 00000001", v, d);
        end
        @(negedge clk);
        force dut.cycle = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.cycle;
        @(negedge clk);
        addr = A_LO;
        re = 1'b1;
        @(negedge clk);
        re = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'd0) begin
            failures++;
            $display("FAIL cycle_wrap_lo: valid=%b data=%h required 1 00000000", rvalid, rdata);
        end
        bus_read(A_HI, d, v);
        checks++;
        if (v !== 1'b1 || d !== 32'd0) begin
            failures++;
            $display("FAIL cycle_wrap_hi: valid=%b data=%h required 1 00000000", v, d);
        end
    endtask

    task automatic test_decode();
        logic [31:0] d;
        logic v;
        bus_read(32'h2000_0000, d, v);
        checks++;
        if (v !== 1'b0) begin
            failures++;
            $display("FAIL nonhit_read_valid: got %b required 0", v);
        end
        @(negedge clk);
        addr = A_LO;
        we = 1'b1;
        re = 1'b1;
        @(negedge clk);
        we = 1'b0;
        re = 1'b0;
        checks++;
        if (rvalid !== 1'b0) begin
            failures++;
            $display("FAIL we_re_no_response: got %b required 0", rvalid);
        end
    endtask

    task automatic test_first_wins_reset();
        logic [31:0] d;
        logic v;
        do_reset();
        bus_write(A_CON, 32'h55);
        bus_write(A_STAT, 32'h777);
        bus_write(A_STAT, 32'h1);
        checks++;
        if (code !== 32'h777 || pass !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL first_write_wins: code=%h pass=%b done=%b required 777 1 0", code, pass, done);
        end
        bus_read(A_STAT, d, v);
        checks++;
        if (v !== 1'b1 || d !== 32'h1) begin
            failures++;
            $display("FAIL status_read_drain: valid=%b data=%h required 1 00000001", v, d);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (done !== 1'b0 || pass !== 1'b0 || code !== 32'h0 || con_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: done=%b pass=%b code=%h cv=%b required 0 0 0 0", done, pass, code, con_valid);
        end
        bus_read(A_CON, d, v);
        checks++;
        if (v !== 1'b1 || d !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset_count: valid=%b data=%h required 1 00000000", v, d);
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_console_drain();
        test_overflow();
        test_cycle();
        test_decode();
        test_first_wins_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
